// File: rtl/wb_waitstate_ram.sv
// Wishbone classic slave: word RAM plus WAIT/COUNT CSRs, with a programmable
// number of wait states inserted before each acknowledge.
module wb_waitstate_ram #(
  parameter logic [11:0] BASE_ADDR    = 12'h380,
  parameter int          DEPTH        = 1024,
  parameter int          WAIT_W       = 16,
  parameter int          DEFAULT_WAIT = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [WAIT_W-1:0] cnt_r, cnt_s;
  logic [WAIT_W-1:0] wait_r;
  logic [31:0]       count_r;
  logic [31:0]       mem_r [DEPTH];

  logic          decoded_s, req_s, is_csr_s, commit_s, ram_we_s;
  logic          wait_wr_s, count_wr_s;
  logic [AW-1:0] idx_s;
  logic [31:0]   ram_q_s, csr_q_s, rd_data_s, wait_merged_s;
  logic          unused_s;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        res[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return res;
  endfunction

  assign decoded_s  = (wbs_adr_i[31:20] == BASE_ADDR);
  assign req_s      = wbs_cyc_i & wbs_stb_i & decoded_s;
  assign is_csr_s   = wbs_adr_i[19];
  assign idx_s      = wbs_adr_i[AW+1:2];
  // Commit only if the master still holds the request in the ack-raising cycle.
  assign commit_s   = (state_r == ST_ACK) & req_s;
  assign ram_we_s   = commit_s & ~is_csr_s & wbs_we_i & ~wb_rst_i;
  assign wait_wr_s  = commit_s & is_csr_s & wbs_we_i & (wbs_adr_i[3:2] == 2'd0);
  assign count_wr_s = commit_s & is_csr_s & wbs_we_i & (wbs_adr_i[3:2] == 2'd1);
  assign ram_q_s    = mem_r[idx_s];
  assign wait_merged_s = merge_lanes(32'(wait_r), wbs_dat_i, wbs_sel_i);
  assign unused_s   = ^{wbs_adr_i[18:AW+2], wbs_adr_i[1:0]};

  // Next-state and wait-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req_s) begin
          cnt_s = wait_r;
          if (wait_r == '0) begin
            state_s = ST_ACK;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!req_s) begin
          state_s = ST_IDLE;
          cnt_s   = '0;
        end else if (cnt_r <= WAIT_W'(1)) begin
          state_s = ST_ACK;
          cnt_s   = '0;
        end else begin
          state_s = ST_WAIT;
          cnt_s   = cnt_r - WAIT_W'(1);
        end
      end
      ST_ACK: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Read-data mux between the CSR bank and the RAM.
  always_comb begin
    csr_q_s   = 32'h0;
    rd_data_s = 32'h0;
    case (wbs_adr_i[3:2])
      2'd0:    csr_q_s = 32'(wait_r);
      2'd1:    csr_q_s = count_r;
      default: csr_q_s = 32'h0;
    endcase
    if (is_csr_s) begin
      rd_data_s = csr_q_s;
    end else begin
      rd_data_s = ram_q_s;
    end
  end

  // FSM, handshake outputs and CSR registers.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'h0;
      wait_r    <= WAIT_W'(DEFAULT_WAIT);
      count_r   <= 32'h0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      wbs_ack_o <= commit_s;
      wbs_dat_o <= (commit_s && !wbs_we_i) ? rd_data_s : 32'h0;
      if (wait_wr_s) begin
        wait_r <= WAIT_W'(wait_merged_s);
      end
      if (count_wr_s) begin
        count_r <= 32'h0;
      end else if (commit_s) begin
        count_r <= count_r + 32'd1;
      end
    end
  end

  // RAM array; deliberately outside reset so contents survive it.
  always_ff @(posedge wb_clk_i) begin
    if (ram_we_s) begin
      mem_r[idx_s] <= merge_lanes(ram_q_s, wbs_dat_i, wbs_sel_i);
    end
  end

endmodule
